// File: rtl/acc_rr_mem_arbiter.sv
// Round-robin arbiter: NUM_CLIENTS accelerator cores onto one shared data-memory port.
// Optional `ARB_TIMEOUT_EN adds arb_timeout_err and a wait-state watchdog.
module acc_rr_mem_arbiter #(
  parameter int NUM_CLIENTS           = 8,
  parameter int ADDR_SIZE             = 32,
  parameter int WRITE_DATA_SIZE       = 32,
  parameter int READ_DATA_SIZE        = 512,
  parameter int HAVE_UPSTREAM_ARBITER = 1,
  parameter int MEM_LATENCY           = 1,
  parameter int TIMEOUT_CYCLES        = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CLIENTS-1:0]               client_read_en,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0]     client_read_addr,
  input  logic [NUM_CLIENTS-1:0]               client_write_en,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0]     client_write_addr,
  input  logic [NUM_CLIENTS*WRITE_DATA_SIZE-1:0] client_write_data,
  output logic [READ_DATA_SIZE-1:0]            client_read_data,
  output logic [NUM_CLIENTS-1:0]               client_read_valid,
  output logic [NUM_CLIENTS-1:0]               client_write_done,
  output logic                                 mem_read_en,
  output logic [ADDR_SIZE-1:0]                 mem_read_addr,
  input  logic [READ_DATA_SIZE-1:0]            mem_read_data,
  output logic                                 mem_write_en,
  output logic [ADDR_SIZE-1:0]                 mem_write_addr,
  output logic [WRITE_DATA_SIZE-1:0]           mem_write_data,
  input  logic                                 upstream_read_valid,
  input  logic                                 upstream_write_done
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                                 arb_timeout_err
`endif
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WRITE_WAIT = 2'd1;
  localparam logic [1:0] S_READ_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP       = 2'd3;

  logic [1:0]                 r_state;
  logic [IW-1:0]              r_rr_ptr;
  logic [IW-1:0]              r_gnt;
  logic [ADDR_SIZE-1:0]       r_addr;
  logic [WRITE_DATA_SIZE-1:0] r_wdata;
  logic [3:0]                 r_lat;
  logic [NUM_CLIENTS-1:0]     w_elig;
  logic [IW-1:0]              w_gnt;
  logic                       w_found;
  logic                       w_wait;
  logic                       w_done;
  logic                       w_timeout;
  logic                       w_finish;

  assign w_elig = client_write_en | client_read_en;
  assign w_wait = (r_state == S_WRITE_WAIT) || (r_state == S_READ_WAIT);

  // First eligible client after the last winner; the last winner itself is checked last.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_CLIENTS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_gnt   = IW'(idx);
      end
    end
  end

  always_comb begin
    w_done = 1'b0;
    if (HAVE_UPSTREAM_ARBITER != 0) begin
      if (r_state == S_WRITE_WAIT)     w_done = upstream_write_done;
      else if (r_state == S_READ_WAIT) w_done = upstream_read_valid;
    end else begin
      w_done = w_wait && (r_lat == 4'(MEM_LATENCY - 1));
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;

  assign w_timeout = w_wait && !w_done && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt      <= '0;
      arb_timeout_err <= 1'b0;
    end else begin
      arb_timeout_err <= w_timeout;
      if (w_wait && !w_done && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                 r_wait_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish = w_done | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_rr_ptr          <= IW'(NUM_CLIENTS - 1);
      r_gnt             <= '0;
      r_addr            <= '0;
      r_wdata           <= '0;
      r_lat             <= '0;
      client_read_data  <= '0;
      client_read_valid <= '0;
      client_write_done <= '0;
    end else begin
      client_read_valid <= '0;
      client_write_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_gnt;
            r_rr_ptr <= w_gnt;
            r_lat    <= '0;
            if (client_write_en[w_gnt]) begin
              r_state <= S_WRITE_WAIT;
              r_addr  <= client_write_addr[w_gnt*ADDR_SIZE +: ADDR_SIZE];
              r_wdata <= client_write_data[w_gnt*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
            end else begin
              r_state <= S_READ_WAIT;
              r_addr  <= client_read_addr[w_gnt*ADDR_SIZE +: ADDR_SIZE];
            end
          end
        end
        S_WRITE_WAIT, S_READ_WAIT: begin
          if (w_finish) begin
            r_state <= S_RESP;
            r_lat   <= '0;
            if (r_state == S_WRITE_WAIT) begin
              client_write_done[r_gnt] <= 1'b1;
            end else begin
              client_read_valid[r_gnt] <= 1'b1;
              // a watchdog abort still releases the client but keeps the old data
              if (w_done) client_read_data <= mem_read_data;
            end
          end else begin
            r_lat <= r_lat + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_write_en   = (r_state == S_WRITE_WAIT);
  assign mem_read_en    = (r_state == S_READ_WAIT);
  assign mem_write_addr = r_addr;
  assign mem_read_addr  = r_addr;
  assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_acc_rr_mem_arbiter.sv
// Randomised bench for acc_rr_mem_arbiter: upstream-handshake instance plus a fixed-latency instance.
module tb_acc_rr_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream-handshake instance
  logic [7:0]   rd_en, wr_en, crv, cwdn;
  logic [255:0] cra, cwa, cwd;
  logic [63:0]  crd, mrd;
  logic         mre, mwe, urv, uwd;
  logic [31:0]  mra, mwa, mwd;
`ifdef ARB_TIMEOUT_EN
  logic terr, l_terr;
`endif

  // fixed-latency instance
  logic [7:0]   l_rd_en, l_wr_en, l_crv, l_cwdn;
  logic [255:0] l_cra, l_cwa, l_cwd;
  logic [63:0]  l_crd, l_mrd;
  logic         l_mre, l_mwe, l_urv, l_uwd;
  logic [31:0]  l_mra, l_mwa, l_mwd;

  acc_rr_mem_arbiter #(
    .NUM_CLIENTS(8), .ADDR_SIZE(32), .WRITE_DATA_SIZE(32), .READ_DATA_SIZE(64),
    .HAVE_UPSTREAM_ARBITER(1), .MEM_LATENCY(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .client_read_en(rd_en), .client_read_addr(cra),
    .client_write_en(wr_en), .client_write_addr(cwa), .client_write_data(cwd),
    .client_read_data(crd), .client_read_valid(crv), .client_write_done(cwdn),
    .mem_read_en(mre), .mem_read_addr(mra), .mem_read_data(mrd),
    .mem_write_en(mwe), .mem_write_addr(mwa), .mem_write_data(mwd),
    .upstream_read_valid(urv), .upstream_write_done(uwd)
`ifdef ARB_TIMEOUT_EN
    , .arb_timeout_err(terr)
`endif
  );

  acc_rr_mem_arbiter #(
    .NUM_CLIENTS(8), .ADDR_SIZE(32), .WRITE_DATA_SIZE(32), .READ_DATA_SIZE(64),
    .HAVE_UPSTREAM_ARBITER(0), .MEM_LATENCY(3), .TIMEOUT_CYCLES(256)
  ) dut_l (
    .clk(clk), .rst_n(rst_n),
    .client_read_en(l_rd_en), .client_read_addr(l_cra),
    .client_write_en(l_wr_en), .client_write_addr(l_cwa), .client_write_data(l_cwd),
    .client_read_data(l_crd), .client_read_valid(l_crv), .client_write_done(l_cwdn),
    .mem_read_en(l_mre), .mem_read_addr(l_mra), .mem_read_data(l_mrd),
    .mem_write_en(l_mwe), .mem_write_addr(l_mwa), .mem_write_data(l_mwd),
    .upstream_read_valid(l_urv), .upstream_write_done(l_uwd)
`ifdef ARB_TIMEOUT_EN
    , .arb_timeout_err(l_terr)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: transaction-level view of the shared port
  int          m_ptr, m_g, m_lat, m_cnt, m_free;
  bit          m_act, m_fire, m_wr, m_pend_prev;
  logic [31:0] m_addr, m_data;
  logic [63:0] m_rdata_exp, m_rdata_pend;
  int          log_q[$];   // completions, encoded client*2 + (write ? 1 : 0)

  function automatic int pick(input int ptr, input logic [7:0] lv);
    for (int k = 1; k <= 8; k++)
      if (lv[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 7; m_act = 0; m_fire = 0; m_rdata_exp = '0;
    m_free = cyc + 1;
    m_pend_prev = |(rd_en | wr_en);
    log_q.delete();
  endtask

  // One clock of traffic: check at the falling edge, then drive the next inputs.
  // lat_mode < 0 picks a random upstream latency per transaction.
  task automatic step(input int lat_mode, input bit rand_req, input bit drop_on_grant);
    int g;
    int kind;
    logic [7:0] exp1;
    @(negedge clk);
    if (m_act && m_fire) begin
      exp1 = 8'(1 << m_g);
      n_chk++;
      if (m_wr ? (cwdn !== exp1 || crv !== 8'h00) : (crv !== exp1 || cwdn !== 8'h00)) begin
        n_fail++;
        $display("FAIL completion_pulse client=%0d wr=%0d valid=%h done=%h required one-hot %h", m_g, m_wr, crv, cwdn, exp1);
      end
      n_chk++;
      if ({mre, mwe} !== 2'b00) begin
        n_fail++;
        $display("FAIL en_deassert read_en=%b write_en=%b required 0 0", mre, mwe);
      end
      if (!m_wr) m_rdata_exp = m_rdata_pend;
      log_q.push_back(m_g * 2 + (m_wr ? 1 : 0));
      if (m_wr) wr_en[m_g] = 1'b0; else rd_en[m_g] = 1'b0;
      m_ptr = m_g; m_act = 0; m_fire = 0; m_free = cyc + 2;
    end else if (m_act) begin
      n_chk++;
      if (mwe !== m_wr || mre !== !m_wr || crv !== 8'h00 || cwdn !== 8'h00 ||
          (m_wr ? (mwa !== m_addr || mwd !== m_data) : (mra !== m_addr))) begin
        n_fail++;
        $display("FAIL wait_hold client=%0d rd=%b wr=%b raddr=%h waddr=%h wdata=%h required wr=%0d addr=%h data=%h",
                 m_g, mre, mwe, mra, mwa, mwd, m_wr, m_addr, m_data);
      end
      m_cnt++;
    end else begin
      n_chk++;
      if ((mre | mwe) !== (m_pend_prev && cyc >= m_free) || crv !== 8'h00 || cwdn !== 8'h00) begin
        n_fail++;
        $display("FAIL grant_timing en=%b valid=%h done=%h required en=%0d and no pulses",
                 mre | mwe, crv, cwdn, m_pend_prev && cyc >= m_free);
      end
      g = pick(m_ptr, rd_en | wr_en);
      if ((mre === 1'b1 || mwe === 1'b1) && g >= 0) begin
        m_wr   = wr_en[g];
        m_addr = m_wr ? cwa[g*32 +: 32] : cra[g*32 +: 32];
        m_data = cwd[g*32 +: 32];
        n_chk++;
        if (mwe !== m_wr || mre !== !m_wr || (m_wr ? (mwa !== m_addr || mwd !== m_data) : (mra !== m_addr))) begin
          n_fail++;
          $display("FAIL grant_select rd=%b wr=%b raddr=%h waddr=%h wdata=%h required client=%0d wr=%0d addr=%h data=%h",
                   mre, mwe, mra, mwa, mwd, g, m_wr, m_addr, m_data);
        end
        m_act = 1; m_g = g; m_cnt = 0;
        m_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        if (drop_on_grant) begin
          if (m_wr) wr_en[g] = 1'b0; else rd_en[g] = 1'b0;
        end
      end
    end
    n_chk++;
    if (crd !== m_rdata_exp) begin
      n_fail++;
      $display("FAIL read_data_hold got=%h required=%h", crd, m_rdata_exp);
    end
    // strobes of the wrong type or outside a wait are noise the DUT must ignore
    mrd = {$urandom, $urandom};
    urv = 1'($urandom_range(0, 1));
    uwd = 1'($urandom_range(0, 1));
    if (m_act) begin
      if (m_cnt == m_lat) begin
        m_fire = 1;
        if (m_wr) uwd = 1'b1;
        else begin urv = 1'b1; m_rdata_pend = mrd; end
      end else if (m_wr) uwd = 1'b0;
      else urv = 1'b0;
    end
    if (rand_req) begin
      for (int i = 0; i < 8; i++) begin
        if (!rd_en[i] && !wr_en[i] && !(m_act && m_g == i) && $urandom_range(0, 3) == 0) begin
          kind = int'($urandom_range(1, 3));
          cra[i*32 +: 32] = $urandom;
          cwa[i*32 +: 32] = $urandom;
          cwd[i*32 +: 32] = $urandom;
          rd_en[i] = kind[0];
          wr_en[i] = kind[1];
        end
      end
    end
    m_pend_prev = |(rd_en | wr_en);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_en = '0; wr_en = '0; urv = 1'b0; uwd = 1'b0; mrd = '0;
    cra = '0; cwa = '0; cwd = '0;
    l_rd_en = '0; l_wr_en = '0; l_urv = 1'b1; l_uwd = 1'b1; l_mrd = '0;
    l_cra = '0; l_cwa = '0; l_cwd = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({crd, crv, cwdn, mre, mwe, mra, mwa, mwd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rdata=%h valid=%h done=%h ren=%b wen=%b raddr=%h waddr=%h wdata=%h required all 0",
               crd, crv, cwdn, mre, mwe, mra, mwa, mwd);
    end
    n_chk++;
    if ({l_crd, l_crv, l_cwdn, l_mre, l_mwe, l_mra, l_mwa, l_mwd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_latency_inst got nonzero, required all 0");
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(0, 0, 0);
  endtask

  task automatic test_all_read();
    for (int i = 0; i < 8; i++) cra[i*32 +: 32] = $urandom;
    rd_en = 8'hFF;
    m_pend_prev = 1'b1;
    log_q.delete();
    for (int c = 0; c < 200 && log_q.size() < 8; c++) step(2, 0, 0);
    n_chk++;
    if (log_q.size() != 8) begin
      n_fail++;
      $display("FAIL all_read_count got=%0d required=8", log_q.size());
    end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      n_chk++;
      if (log_q[i] != 2 * i) begin
        n_fail++;
        $display("FAIL all_read_order slot=%0d got code=%0d required=%0d", i, log_q[i], 2 * i);
      end
    end
  endtask

  task automatic test_wr_rd();
    cwa[3*32 +: 32] = 32'h0000_5000;
    cra[3*32 +: 32] = 32'h0000_5000;
    cwd[3*32 +: 32] = 32'hDEAD_BEEF;
    rd_en[3] = 1'b1; wr_en[3] = 1'b1;
    m_pend_prev = 1'b1;
    log_q.delete();
    for (int c = 0; c < 40 && log_q.size() < 2; c++) step(1, 0, 0);
    n_chk++;
    if (log_q.size() != 2 || log_q[0] != 7 || log_q[1] != 6) begin
      n_fail++;
      $display("FAIL write_before_read got %0d completions first=%0d required write(7) then read(6)",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : -1);
    end
  endtask

  task automatic test_drop();
    cwa[2*32 +: 32] = $urandom;
    cwd[2*32 +: 32] = $urandom;
    wr_en[2] = 1'b1;
    m_pend_prev = 1'b1;
    log_q.delete();
    for (int c = 0; c < 20; c++) step(3, 0, 1);
    n_chk++;
    if (log_q.size() != 1 || log_q[0] != 5) begin
      n_fail++;
      $display("FAIL dropped_write got %0d completions required exactly one write_done for client 2", log_q.size());
    end
  endtask

  task automatic test_latency();
    int en_cnt;
    bit seen;
    logic [31:0] addr;
    logic [63:0] last;
    en_cnt = 0; seen = 0; last = '0;
    addr = $urandom;
    l_cra[5*32 +: 32] = addr;
    l_rd_en[5] = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (l_crv !== 8'h00) begin
        seen = 1;
        n_chk++;
        if (l_crv !== 8'h20 || l_mre !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_valid valid=%h en=%b required valid=20 en=0", l_crv, l_mre);
        end
        n_chk++;
        if (en_cnt != 3) begin
          n_fail++;
          $display("FAIL latency_en_cycles got=%0d required=3", en_cnt);
        end
        n_chk++;
        if (l_crd !== last) begin
          n_fail++;
          $display("FAIL latency_rdata got=%h required=%h", l_crd, last);
        end
        l_rd_en[5] = 1'b0;
      end else if (l_mre === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (l_mra !== addr) begin
          n_fail++;
          $display("FAIL latency_addr got=%h required=%h", l_mra, addr);
        end
        l_mrd = {$urandom, $urandom};
        last  = l_mrd;
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL latency_timeout no read_valid within 30 cycles, required one");
    end
    @(negedge clk);
    n_chk++;
    if (l_crv !== 8'h00) begin
      n_fail++;
      $display("FAIL latency_pulse_width valid=%h required 00", l_crv);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) step(-1, 1, 0);
    for (int c = 0; c < 400 && (m_act || (rd_en | wr_en) != 8'h00); c++) step(-1, 0, 0);
    n_chk++;
    if (m_act || (rd_en | wr_en) != 8'h00) begin
      n_fail++;
      $display("FAIL random_drain pending=%h active=%0d required all served", rd_en | wr_en, m_act);
    end
    repeat (3) step(-1, 0, 0);
  endtask

  task automatic test_reset_mid();
    cra[4*32 +: 32] = $urandom;
    rd_en[4] = 1'b1;
    m_pend_prev = 1'b1;
    for (int c = 0; c < 10 && !m_act; c++) step(1000, 0, 0);
    repeat (2) step(1000, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({crd, crv, cwdn, mre, mwe, mra, mwa, mwd} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs rdata=%h valid=%h done=%h ren=%b wen=%b raddr=%h required all 0",
               crd, crv, cwdn, mre, mwe, mra);
    end
    cra[0 +: 32] = $urandom;
    cra[6*32 +: 32] = $urandom;
    rd_en[0] = 1'b1; rd_en[6] = 1'b1;
    urv = 1'b0; uwd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 60 && log_q.size() < 3; c++) step(1, 0, 0);
    n_chk++;
    if (log_q.size() != 3 || log_q[0] != 0 || log_q[1] != 8 || log_q[2] != 12) begin
      n_fail++;
      $display("FAIL reset_mid_order got %0d completions first=%0d required clients 0,4,6",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : -1);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int en_cnt;
    int gap;
    bit seen;
    rst_n = 1'b0;
    rd_en = '0; wr_en = '0; urv = 1'b0; uwd = 1'b0;
    cra[1*32 +: 32] = $urandom;
    cra[2*32 +: 32] = $urandom;
    rd_en[1] = 1'b1; rd_en[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0; gap = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      mrd = {$urandom, $urandom};
      if (terr === 1'b1) begin
        seen = 1;
        n_chk++;
        if (en_cnt != 16 || crv !== 8'h02 || crd !== 64'h0 || mre !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_err en_cycles=%0d valid=%h rdata=%h en=%b required 16, 02, 0, 0",
                   en_cnt, crv, crd, mre);
        end
        rd_en[1] = 1'b0;
      end else if (seen) begin
        gap++;
        if (mre === 1'b1) begin
          n_chk++;
          if (gap != 2 || mra !== cra[2*32 +: 32]) begin
            n_fail++;
            $display("FAIL timeout_next_grant gap=%0d addr=%h required gap=2 addr=%h", gap, mra, cra[2*32 +: 32]);
          end
          break;
        end
      end else if (mre === 1'b1) en_cnt++;
    end
    n_chk++;
    if (!seen || gap == 0) begin
      n_fail++;
      $display("FAIL timeout_missing err_seen=%0d required err then next grant", seen);
    end
    rst_n = 1'b0;
    rd_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_read();
    test_wr_rd();
    test_drop();
    test_latency();
    test_random();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
